// File: rtl/mult_sweep_driver.sv
// Self-test initiator for the shift-add multiplier: walks every (a,b) operand pair,
// checks each product, counts mismatches and aborts on a hung operation.
module mult_sweep_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int ERRW    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               go_i,
  input  logic               mult_ready_i,
  input  logic               mult_done_i,
  input  logic [2*WIDTH-1:0] mult_product_i,
  output logic               mult_start_o,
  output logic [WIDTH-1:0]   mult_multiplicand_o,
  output logic [WIDTH-1:0]   mult_multiplier_o,
  output logic               busy_o,
  output logic               finished_o,
  output logic               timed_out_o,
  output logic [ERRW-1:0]    err_count_o,
  output logic [WIDTH-1:0]   first_err_a_o,
  output logic [WIDTH-1:0]   first_err_b_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   fa_q, fb_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [TW-1:0]      tmo_q;
  logic [ERRW-1:0]    err_q, err_d;
  logic               fin_q, tmo_flag_q, have_err_q;
  logic               go_acc, mismatch, proto_err;
  logic [2*WIDTH-1:0] expect_w;

  // A go that clears the counter may coincide with a stray done; the stray done still counts.
  always_comb begin
    go_acc    = go_i && (state_q == S_IDLE || state_q == S_FINISH);
    expect_w  = (2*WIDTH)'(a_q) * (2*WIDTH)'(b_q);
    mismatch  = (state_q == S_CHECK) && (prod_q != expect_w);
    proto_err = mult_done_i && (state_q != S_WAIT);
    err_d     = go_acc ? '0 : err_q;
    if (mismatch && (err_d != '1)) err_d = err_d + ERRW'(1);
    if (proto_err && (err_d != '1)) err_d = err_d + ERRW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      fa_q       <= '0;
      fb_q       <= '0;
      prod_q     <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      fin_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
      have_err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        S_IDLE, S_FINISH: begin
          if (go_i) begin
            a_q        <= '0;
            b_q        <= '0;
            fa_q       <= '0;
            fb_q       <= '0;
            fin_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
            have_err_q <= 1'b0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mult_ready_i) begin
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mult_done_i) begin
            prod_q  <= mult_product_i;
            state_q <= S_CHECK;
          end else if (tmo_q == TMO_LAST) begin
            tmo_flag_q <= 1'b1;
            fin_q      <= 1'b1;
            state_q    <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_CHECK: begin
          if (mismatch && !have_err_q) begin
            have_err_q <= 1'b1;
            fa_q       <= a_q;
            fb_q       <= b_q;
          end
          // Operands stay at the last pair once the sweep completes.
          if (a_q == '1 && b_q == '1) begin
            fin_q   <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            b_q <= b_q + WIDTH'(1);
            if (b_q == '1) a_q <= a_q + WIDTH'(1);
            state_q <= S_ISSUE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mult_start_o        = (state_q == S_ISSUE) && mult_ready_i;
  assign mult_multiplicand_o = a_q;
  assign mult_multiplier_o   = b_q;
  assign busy_o              = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign finished_o          = fin_q;
  assign timed_out_o         = tmo_flag_q;
  assign err_count_o         = err_q;
  assign first_err_a_o       = fa_q;
  assign first_err_b_o       = fb_q;

endmodule

// File: tb/tb_mult_sweep_driver.sv
// Bench for mult_sweep_driver at WIDTH=4: behavioural multiplier with random latency,
// ready gaps, injected wrong products, a hung pair, mid-sweep reset and stray done pulses.
module tb_mult_sweep_driver;

  localparam int W   = 4;
  localparam int TMO = 64;
  localparam int EW  = 16;
  localparam int NP  = 256;

  logic          clk = 1'b0;
  logic          rst_i, go_i, mult_ready_i, mult_done_i;
  logic [2*W-1:0] mult_product_i;
  logic          mult_start_o, busy_o, finished_o, timed_out_o;
  logic [W-1:0]  mult_multiplicand_o, mult_multiplier_o, first_err_a_o, first_err_b_o;
  logic [EW-1:0] err_count_o;

  always #5 clk = ~clk;

  mult_sweep_driver #(.WIDTH(W), .TIMEOUT(TMO), .ERRW(EW)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .go_i               (go_i),
    .mult_ready_i       (mult_ready_i),
    .mult_done_i        (mult_done_i),
    .mult_product_i     (mult_product_i),
    .mult_start_o       (mult_start_o),
    .mult_multiplicand_o(mult_multiplicand_o),
    .mult_multiplier_o  (mult_multiplier_o),
    .busy_o             (busy_o),
    .finished_o         (finished_o),
    .timed_out_o        (timed_out_o),
    .err_count_o        (err_count_o),
    .first_err_a_o      (first_err_a_o),
    .first_err_b_o      (first_err_b_o)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Multiplier reference state
  bit         bad_pair [NP];
  logic [7:0] bad_val  [NP];
  int         hang_idx  = -1;
  bit         fixed_lat = 1'b0;
  bit         spur_req  = 1'b0;
  int         exp_idx   = 0;
  int         n_starts  = 0;
  int         start_cyc = 0;
  int         cyc_n     = 0;
  bit         m_busy    = 1'b0;
  int         m_cnt     = 0;
  int         cur_idx   = 0;
  logic [W-1:0] ra, rb, sa, sb;
  logic       st, sr;

  always @(posedge clk) cyc_n++;

  task automatic clear_faults();
    for (int i = 0; i < NP; i++) begin
      bad_pair[i] = 1'b0;
      bad_val[i]  = 8'd0;
    end
  endtask

  initial begin
    mult_ready_i   = 1'b1;
    mult_done_i    = 1'b0;
    mult_product_i = '0;
    forever begin
      @(negedge clk);
      st = mult_start_o;
      sa = mult_multiplicand_o;
      sb = mult_multiplier_o;
      sr = rst_i;
      if (m_busy && !sr) begin
        chk("op_a_stable", 32'(sa), 32'(ra));
        chk("op_b_stable", 32'(sb), 32'(rb));
      end
      @(posedge clk);
      #1;
      mult_done_i = 1'b0;
      if (sr) begin
        m_busy       = 1'b0;
        mult_ready_i = 1'b1;
      end else if (m_busy) begin
        if (cur_idx != hang_idx) begin
          m_cnt--;
          if (m_cnt == 0) begin
            mult_done_i    = 1'b1;
            mult_product_i = bad_pair[cur_idx] ? bad_val[cur_idx] : 8'(ra) * 8'(rb);
            m_busy         = 1'b0;
            mult_ready_i   = fixed_lat ? 1'b1 : ($urandom_range(0, 3) != 0);
          end
        end
      end else if (st) begin
        chk("start_order", 32'({sa, sb}), 32'(exp_idx));
        ra           = sa;
        rb           = sb;
        cur_idx      = int'({sa, sb});
        exp_idx++;
        n_starts++;
        start_cyc    = cyc_n;
        m_busy       = 1'b1;
        m_cnt        = fixed_lat ? 5 : int'($urandom_range(1, 6));
        mult_ready_i = 1'b0;
      end else if (spur_req) begin
        mult_done_i    = 1'b1;
        mult_product_i = '0;
        spur_req       = 1'b0;
      end else begin
        mult_ready_i = fixed_lat ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic pulse_go(input bit restart);
    @(negedge clk);
    #1;
    if (restart) begin
      exp_idx  = 0;
      n_starts = 0;
    end
    go_i = 1'b1;
    @(negedge clk);
    #1;
    go_i = 1'b0;
  endtask

  task automatic wait_fin(input int budget);
    int n = 0;
    while (finished_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (finished_o !== 1'b1) chk("finish_wait", 32'(0), 32'(1));
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n_starts < target) chk("starts_wait", 32'(n_starts), 32'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    int exp_err, first;
    int n;
    rst_i = 1'b1;
    go_i  = 1'b1;
    clear_faults();

    // Reset held two cycles with go high
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_finished", 32'(finished_o), 32'(0));
    chk("rst_timed_out", 32'(timed_out_o), 32'(0));
    chk("rst_err", 32'(err_count_o), 32'(0));
    chk("rst_start", 32'(mult_start_o), 32'(0));
    chk("rst_a", 32'(mult_multiplicand_o), 32'(0));
    chk("rst_b", 32'(mult_multiplier_o), 32'(0));
    chk("rst_fea", 32'(first_err_a_o), 32'(0));
    chk("rst_feb", 32'(first_err_b_o), 32'(0));
    #1;
    rst_i = 1'b0;
    go_i  = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'(0));
    chk("idle_starts", 32'(n_starts), 32'(0));

    // Ideal multiplier, fixed latency 5
    fixed_lat = 1'b1;
    pulse_go(1'b1);
    wait_fin(20000);
    chk("ideal_starts", 32'(n_starts), 32'(NP));
    chk("ideal_finished", 32'(finished_o), 32'(1));
    chk("ideal_err", 32'(err_count_o), 32'(0));
    chk("ideal_tmo", 32'(timed_out_o), 32'(0));
    chk("ideal_a", 32'(mult_multiplicand_o), 32'(15));
    chk("ideal_b", 32'(mult_multiplier_o), 32'(15));
    chk("ideal_busy", 32'(busy_o), 32'(0));

    // Wrong product for (3,5)
    fixed_lat = 1'b0;
    bad_pair[3*16+5] = 1'b1;
    bad_val[3*16+5]  = 8'd14;
    pulse_go(1'b1);
    wait_fin(20000);
    chk("one_err_cnt", 32'(err_count_o), 32'(1));
    chk("one_err_a", 32'(first_err_a_o), 32'(3));
    chk("one_err_b", 32'(first_err_b_o), 32'(5));
    chk("one_err_starts", 32'(n_starts), 32'(NP));
    chk("one_err_fin", 32'(finished_o), 32'(1));

    // Random sets of wrong products
    for (int it = 0; it < 2; it++) begin
      clear_faults();
      n = int'($urandom_range(2, 6));
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = int'($urandom_range(0, NP - 1));
        bad_pair[idx] = 1'b1;
        bad_val[idx]  = 8'((((idx / 16) * (idx % 16)) + int'($urandom_range(1, 255))) % 256);
      end
      exp_err = 0;
      first   = -1;
      for (int i = 0; i < NP; i++) begin
        if (bad_pair[i]) begin
          exp_err++;
          if (first < 0) first = i;
        end
      end
      pulse_go(1'b1);
      wait_fin(20000);
      chk("rand_err_cnt", 32'(err_count_o), 32'(exp_err));
      chk("rand_err_a", 32'(first_err_a_o), 32'(first / 16));
      chk("rand_err_b", 32'(first_err_b_o), 32'(first % 16));
      chk("rand_starts", 32'(n_starts), 32'(NP));
      chk("rand_tmo", 32'(timed_out_o), 32'(0));
    end

    // Hung multiplier on (2,7), with one earlier mismatch at (1,3)
    clear_faults();
    bad_pair[1*16+3] = 1'b1;
    bad_val[1*16+3]  = 8'd0;
    hang_idx = 2*16+7;
    pulse_go(1'b1);
    wait_fin(20000);
    chk("tmo_latency", 32'(cyc_n - start_cyc), 32'(TMO));
    chk("tmo_flag", 32'(timed_out_o), 32'(1));
    chk("tmo_a", 32'(mult_multiplicand_o), 32'(2));
    chk("tmo_b", 32'(mult_multiplier_o), 32'(7));
    chk("tmo_starts", 32'(n_starts), 32'(2*16+8));
    chk("tmo_err", 32'(err_count_o), 32'(1));
    chk("tmo_fea", 32'(first_err_a_o), 32'(1));
    chk("tmo_feb", 32'(first_err_b_o), 32'(3));
    chk("tmo_busy", 32'(busy_o), 32'(0));

    // Reset mid-operation at (1,9)
    hang_idx = -1;
    clear_faults();
    fixed_lat = 1'b1;
    do_reset();
    pulse_go(1'b1);
    n = 0;
    while (!(m_busy && cur_idx == 1*16+9) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!(m_busy && cur_idx == 1*16+9)) chk("midrst_wait", 32'(0), 32'(1));
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy_o), 32'(0));
    chk("midrst_start", 32'(mult_start_o), 32'(0));
    chk("midrst_err", 32'(err_count_o), 32'(0));
    chk("midrst_a", 32'(mult_multiplicand_o), 32'(0));
    chk("midrst_b", 32'(mult_multiplier_o), 32'(0));
    #1;
    rst_i = 1'b0;
    fixed_lat = 1'b0;
    pulse_go(1'b1);
    wait_fin(20000);
    chk("restart_starts", 32'(n_starts), 32'(NP));
    chk("restart_err", 32'(err_count_o), 32'(0));

    // Stray done in FINISH, then go while busy
    #1;
    spur_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur_err", 32'(err_count_o), 32'(1));
    chk("spur_fea", 32'(first_err_a_o), 32'(0));
    chk("spur_feb", 32'(first_err_b_o), 32'(0));
    chk("spur_fin", 32'(finished_o), 32'(1));
    pulse_go(1'b1);
    wait_starts(20, 5000);
    pulse_go(1'b0);
    chk("busygo_busy", 32'(busy_o), 32'(1));
    chk("busygo_err", 32'(err_count_o), 32'(0));
    wait_fin(20000);
    chk("busygo_starts", 32'(n_starts), 32'(NP));
    chk("busygo_err_end", 32'(err_count_o), 32'(0));
    chk("busygo_a", 32'(mult_multiplicand_o), 32'(15));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
